// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for the sobel edge core: feeds one raster frame, resets the core between
// frames, tags core outputs with valid/sof/eof and reports completion or stream gaps.
module sobel_frame_ctrl #(
  parameter int unsigned WORD_SIZE = 8,
  parameter int unsigned COLS      = 10,
  parameter int unsigned ROWS      = 8,
  parameter int unsigned CORE_LAT  = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  input  logic [WORD_SIZE-1:0] in_pixel,
  output logic                 in_ready,
  output logic                 core_reset,
  output logic [WORD_SIZE-1:0] core_pixel,
  input  logic [WORD_SIZE-1:0] core_out,
  output logic                 out_valid,
  output logic [WORD_SIZE-1:0] out_pixel,
  output logic                 out_sof,
  output logic                 out_eof,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned PipeDepth = CORE_LAT + 1;
  localparam int unsigned RowW      = $clog2(ROWS);
  localparam int unsigned ColW      = $clog2(COLS);
  localparam int unsigned DrainW    = $clog2(CORE_LAT + 2);

  localparam logic [RowW-1:0]   LastRow   = RowW'(ROWS - 1);
  localparam logic [ColW-1:0]   LastCol   = ColW'(COLS - 1);
  localparam logic [RowW-1:0]   FirstRow  = RowW'(2);
  localparam logic [ColW-1:0]   FirstCol  = ColW'(2);
  localparam logic [DrainW-1:0] LastDrain = DrainW'(CORE_LAT);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StError} state_e;

  typedef struct packed {
    logic valid;
    logic sof;
    logic eof;
  } tag_t;

  state_e                   state_q, state_d;
  logic [RowW-1:0]          row_q, row_d;
  logic [ColW-1:0]          col_q, col_d;
  logic [DrainW-1:0]        drain_q, drain_d;
  logic [WORD_SIZE-1:0]     pixel_q, pixel_d;
  tag_t [PipeDepth-1:0]     tag_q;
  tag_t                     tag_in;
  logic                     clear_pipe;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    drain_d    = drain_q;
    pixel_d    = '0;
    tag_in     = '0;
    clear_pipe = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          row_d   = '0;
          col_d   = '0;
        end
      end
      StRun: begin
        if (in_valid) begin
          pixel_d      = in_pixel;
          tag_in.valid = (row_q >= FirstRow) && (col_q >= FirstCol);
          tag_in.sof   = (row_q == FirstRow) && (col_q == FirstCol);
          tag_in.eof   = (row_q == LastRow) && (col_q == LastCol);
          if (col_q == LastCol) begin
            col_d = '0;
            if (row_q == LastRow) begin
              row_d   = '0;
              drain_d = '0;
              state_d = StDrain;
            end else begin
              row_d = row_q + RowW'(1);
            end
          end else begin
            col_d = col_q + ColW'(1);
          end
        end else begin
          // The core cannot stall, so any gap corrupts the frame.
          state_d = StError;
        end
      end
      StDrain: begin
        if (drain_q == LastDrain) begin
          state_d = StIdle;
        end else begin
          drain_d = drain_q + DrainW'(1);
        end
      end
      StError: begin
        clear_pipe = 1'b1;
        if (start) begin
          state_d = StRun;
          row_d   = '0;
          col_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      row_q   <= '0;
      col_q   <= '0;
      drain_q <= '0;
      pixel_q <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      drain_q <= drain_d;
      pixel_q <= pixel_d;
      if (clear_pipe) begin
        tag_q <= '0;
      end else begin
        tag_q <= {tag_q[PipeDepth-2:0], tag_in};
      end
    end
  end

  always_comb begin
    in_ready   = (state_q == StRun);
    core_reset = (state_q == StIdle) || (state_q == StError);
    core_pixel = pixel_q;
    busy       = (state_q == StRun) || (state_q == StDrain);
    done       = (state_q == StDrain) && (drain_q == LastDrain);
    error      = (state_q == StError);
    out_valid  = tag_q[PipeDepth-1].valid;
    out_sof    = tag_q[PipeDepth-1].sof;
    out_eof    = tag_q[PipeDepth-1].eof;
    out_pixel  = out_valid ? core_out : '0;
  end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Scoreboard bench for sobel_frame_ctrl with a behavioural sobel core and a frame-level model.
module tb_sobel_frame_ctrl;

  localparam int WS   = 8;
  localparam int COLS = 10;
  localparam int ROWS = 8;
  localparam int LAT  = 3;
  localparam int NPIX = ROWS * COLS;
  localparam int HL   = 2 * COLS + 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic          in_valid;
  logic [WS-1:0] in_pixel;
  logic          in_ready;
  logic          core_reset;
  logic [WS-1:0] core_pixel;
  logic [WS-1:0] core_out;
  logic          out_valid;
  logic [WS-1:0] out_pixel;
  logic          out_sof;
  logic          out_eof;
  logic          busy;
  logic          done;
  logic          error;

  sobel_frame_ctrl #(
    .WORD_SIZE(WS),
    .COLS     (COLS),
    .ROWS     (ROWS),
    .CORE_LAT (LAT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .in_ready  (in_ready),
    .core_reset(core_reset),
    .core_pixel(core_pixel),
    .core_out  (core_out),
    .out_valid (out_valid),
    .out_pixel (out_pixel),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [WS-1:0] pix;
    logic          sof;
    logic          eof;
  } exp_t;

  exp_t exp_q[$];
  int   frame[ROWS][COLS];
  int   n_tests = 0;
  int   n_fail = 0;
  int   done_count = 0;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // w[i][j] is the pixel at row r-2+i, column c-2+j of the 3x3 window.
  function automatic int sobel3(input int w[3][3]);
    int gx, gy, s;
    gx = (w[0][2] + 2 * w[1][2] + w[2][2]) - (w[0][0] + 2 * w[1][0] + w[2][0]);
    gy = (w[2][0] + 2 * w[2][1] + w[2][2]) - (w[0][0] + 2 * w[0][1] + w[0][2]);
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return (s > 255) ? 255 : s;
  endfunction

  // ---------------- behavioural sobel core (stream, line history, fixed latency)
  int            hist[HL];
  logic [WS-1:0] dline[LAT];

  function automatic int core_calc(input int newest);
    int w[3][3];
    int idx;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        idx = (2 - i) * COLS + (2 - j);
        w[i][j] = (idx == 0) ? newest : hist[idx-1];
      end
    end
    return sobel3(w);
  endfunction

  always @(posedge clock) begin
    if (core_reset) begin
      for (int i = 0; i < HL; i++) hist[i] <= 0;
      for (int i = 0; i < LAT; i++) dline[i] <= '0;
    end else begin
      for (int i = HL - 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0] <= int'(core_pixel);
      dline[0] <= WS'(core_calc(int'(core_pixel)));
      for (int i = LAT - 1; i > 0; i--) dline[i] <= dline[i-1];
    end
  end

  assign core_out = dline[LAT-1];

  // ---------------- reference model: expected outputs of a frame from its pixel array
  function automatic int ref_window(input int r, input int c);
    int w[3][3];
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) w[i][j] = frame[r-2+i][c-2+j];
    return sobel3(w);
  endfunction

  // Interior windows whose last pixel index is <= upto, in raster order.
  task automatic push_expected(input int upto);
    exp_t e;
    for (int r = 2; r < ROWS; r++) begin
      for (int c = 2; c < COLS; c++) begin
        if (r * COLS + c <= upto) begin
          e.pix = WS'(ref_window(r, c));
          e.sof = (r == 2 && c == 2);
          e.eof = (r == ROWS - 1 && c == COLS - 1);
          exp_q.push_back(e);
        end
      end
    end
  endtask

  // ---------------- monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_pixel", int'(out_pixel), int'(e.pix));
          check("out_sof", int'(out_sof), int'(e.sof));
          check("out_eof", int'(out_eof), int'(e.eof));
        end
      end else begin
        check("out_gated", int'({out_sof, out_eof, out_pixel}), 0);
      end
      if (done) done_count++;
      if (done || out_eof) check("done_with_eof", int'(done), int'(out_eof));
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 0);
    check({tag, "_core_reset"}, int'(core_reset), 1);
    check({tag, "_core_pixel"}, int'(core_pixel), 0);
    check({tag, "_out"}, int'({out_valid, out_sof, out_eof, out_pixel}), 0);
    check({tag, "_busy_done_err"}, int'({busy, done, error}), 0);
  endtask

  task automatic fill_random();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) frame[r][c] = int'($urandom_range(0, 255));
  endtask

  // Called and returns at #1 after a rising edge. gap/abort < 0 disables them.
  task automatic run_frame(input int gap, input int abort, input bit poke);
    int  lat;
    int  done_before;
    bit  got;
    if (gap >= 0) push_expected(gap - 3);
    else if (abort >= 0) push_expected(abort - 5);
    else push_expected(NPIX - 1);
    done_before = done_count;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("run_in_ready", int'(in_ready), 1);
    check("run_core_reset", int'(core_reset), 0);
    check("run_busy_noerr", int'({busy, error}), 2);
    for (int k = 0; k < NPIX; k++) begin
      if (k == abort) begin
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_vals("async_reset");
        check("pre_reset_outputs_seen", exp_q.size(), 0);
        exp_q.delete();
        @(posedge clock); #1;
        check_reset_vals("held_reset");
        reset = 1'b0;
        @(posedge clock); #1;
        return;
      end
      if (k == gap) begin
        in_valid = 1'b0;
        @(posedge clock); #1;
        check("gap_error", int'(error), 1);
        check("gap_in_ready", int'(in_ready), 0);
        check("gap_core_reset", int'(core_reset), 1);
        check("gap_busy", int'(busy), 0);
        @(posedge clock); #1;
        check("gap_out_valid", int'(out_valid), 0);
        check("gap_outputs_seen", exp_q.size(), 0);
        return;
      end
      in_valid = 1'b1;
      in_pixel = WS'(frame[k / COLS][k % COLS]);
      start = poke && (k == 20);
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    in_pixel = '0;
    start = 1'b0;
    got = 1'b0;
    for (lat = 1; lat <= 20; lat++) begin
      @(negedge clock);
      if (poke) start = (lat == 1);
      if (done) begin
        got = 1'b1;
        if (poke) start = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    check("done_seen", int'(got), 1);
    check("done_latency", lat, LAT + 1);
    @(posedge clock); #1;
    start = 1'b0;
    check("idle_after_done", int'({busy, in_ready, core_reset}), 1);
    check("frame_outputs_seen", exp_q.size(), 0);
    check("done_once", done_count - done_before, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    in_valid = 1'b0;
    in_pixel = '0;
    #12;
    check_reset_vals("reset");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check_reset_vals("idle");

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) frame[r][c] = 50;
    run_frame(-1, -1, 1'b0);

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) frame[r][c] = (c < 5) ? 0 : 255;
    run_frame(-1, -1, 1'b0);

    fill_random();
    run_frame(37, -1, 1'b0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("error_sticky", int'(error), 1);

    fill_random();
    run_frame(-1, -1, 1'b0);
    fill_random();
    run_frame(-1, -1, 1'b1);
    fill_random();
    run_frame(-1, -1, 1'b0);

    fill_random();
    run_frame(-1, 40, 1'b0);
    fill_random();
    run_frame(-1, -1, 1'b0);

    for (int i = 0; i < 3; i++) begin
      fill_random();
      run_frame(int'($urandom_range(0, NPIX - 1)), -1, 1'b0);
      fill_random();
      run_frame(-1, -1, 1'b0);
    end

    repeat (3) @(posedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_frame_ctrl.md
Name: sobel_frame_ctrl

Overview:
Frame sequencer wrapped around the sobel edge-detector core. Accepts one raster-order frame of ROWS x COLS pixels as an unbroken stream and drives the core's pixel input and reset. Tags the core's outputs with valid, start-of-frame and end-of-frame, masking border windows. Drains the core pipeline and reports completion or stream errors to the frame-level scheduler.

Parameters:
- WORD_SIZE, 8: pixel width; must match the core.
- COLS, 10: pixels per row; must equal the core's ROW_SIZE.
- ROWS, 8: rows per frame; minimum 3.
- CORE_LAT, 3: cycles from core_pixel to the matching core_out.

Ports:
- clock, input, 1: sole clock.
- reset, input, 1: asynchronous, active-high reset.
- start, input, 1: one-cycle request to begin a frame.
- in_valid, input, 1: upstream pixel valid.
- in_pixel, input, WORD_SIZE: upstream pixel.
- in_ready, output, 1: controller accepts in_pixel this cycle.
- core_reset, output, 1: drives the sobel core reset.
- core_pixel, output, WORD_SIZE: drives the sobel core inputPixel; registered.
- core_out, input, WORD_SIZE: sobel core outputPixel.
- out_valid, output, 1: out_pixel is an interior result.
- out_pixel, output, WORD_SIZE: core_out when out_valid, else 0.
- out_sof, output, 1: first valid output of the frame.
- out_eof, output, 1: last valid output of the frame.
- busy, output, 1: high in RUN or DRAIN.
- done, output, 1: one-cycle frame-complete pulse.
- error, output, 1: sticky stream-gap flag.

Behaviour:
- Async reset:
  - state=IDLE; row, col, drain counter and tag pipe cleared.
  - core_pixel=0, core_reset=1.
  - in_ready, out_valid, out_sof, out_eof, busy, done, error all 0.
- States: IDLE, RUN, DRAIN, ERROR.
- IDLE:
  - in_ready=0, core_reset=1, core_pixel<=0.
  - start -> RUN next cycle with row=col=0. In RUN, core_reset=0.
- RUN:
  - in_ready=1.
  - Each cycle with in_valid=1 the pixel is accepted: core_pixel<=in_pixel, and a tag is pushed into the tag pipe.
  - Tag contents:
    - valid = (row>=2 && col>=2).
    - sof = (row==2 && col==2).
    - eof = (row==ROWS-1 && col==COLS-1).
  - col wraps from COLS-1 to 0 with row+1.
  - Accepting pixel (ROWS-1, COLS-1) -> DRAIN.
  - in_valid=0 in any RUN cycle -> ERROR. The core has no stall, so gaps are illegal.
- Tag pipe:
  - Shift register, depth CORE_LAT+1, advances every cycle.
  - Zeros are pushed in every non-accepting cycle.
  - Tail drives out_valid, out_sof and out_eof, so a tag reaches the outputs CORE_LAT+1 cycles after its pixel's accept cycle.
  - out_pixel = out_valid ? core_out : 0 (combinational gate).
- DRAIN:
  - in_ready=0, core_pixel<=0.
  - Counter runs CORE_LAT+1 cycles.
  - done=1 in the final DRAIN cycle, coincident with out_eof; then -> IDLE.
- ERROR:
  - error=1 (sticky), core_reset=1.
  - Tag pipe cleared, so out_valid=0 from the next cycle.
  - in_ready=0.
  - start -> RUN with error cleared and counters zeroed.
- start is ignored in RUN and DRAIN.
- Simultaneous events:
  - start in the cycle done is asserted: ignored; a new start is honoured from IDLE.
  - reset at any time: immediate return to the reset state; in-flight tags are discarded.
- Valid outputs per frame: (ROWS-2)*(COLS-2). At defaults this is 48.
- busy = (state==RUN || state==DRAIN).

Test Plan:
- Reset, then start and 80 consecutive pixels all 50 -> exactly 48 out_valid cycles, all out_pixel=0. out_sof on the first valid cycle, out_eof on the 48th. done coincident with out_eof, 4 cycles after the last accept; busy falls next cycle.
- Frame with cols 0-4 = 0 and cols 5-9 = 255 -> out_pixel=255 for windows spanning the edge and 0 elsewhere. No out_valid for rows 0-1 or cols 0-1.
- in_valid dropped at pixel 37 -> ERROR next cycle: error=1, in_ready=0, core_reset=1, out_valid=0 after 1 cycle. Then start -> error=0 and a full frame completes normally.
- start pulsed during RUN and during DRAIN -> no effect; output count stays 48 and done pulses once.
- Async reset asserted mid-frame at pixel 40 -> all outputs at reset values immediately. After release, a new start gives a clean 48-output frame.
- Back-to-back frames (start one cycle after done) -> second frame's out_sof only after the core was reset in IDLE. No stale first-frame data with out_valid=1.
